// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, fed by the ROB commit path.
// Define REGFILE_BYPASS_EN to forward the same-cycle commit onto the read ports.
module reg_file_rename #(
  parameter int REG_NUM  = 32,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                rename_en,
  input  logic [REG_W-1:0]    rename_rd,
  input  logic [ROB_ID_W-1:0] rename_rob_id,
  input  logic                commit_en,
  input  logic [REG_W-1:0]    commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]   commit_value,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  output logic [DATA_W-1:0]   rs1_value,
  output logic                rs1_busy,
  output logic [ROB_ID_W-1:0] rs1_tag,
  output logic [DATA_W-1:0]   rs2_value,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs2_tag
);

  logic [DATA_W-1:0]   value_q [REG_NUM];
  logic                busy_q  [REG_NUM];
  logic [ROB_ID_W-1:0] tag_q   [REG_NUM];

  logic [REG_NUM-1:0] commit_hit;
  logic [REG_NUM-1:0] rename_hit;
  logic [REG_NUM-1:0] retire_hit;

  // Per-register decode; entry 0 never matches so x0 stays at zero.
  always_comb begin
    commit_hit = '0;
    rename_hit = '0;
    retire_hit = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      commit_hit[i] = commit_en && (commit_rd == REG_W'(i));
      rename_hit[i] = rename_en && (rename_rd == REG_W'(i));
      retire_hit[i] = commit_hit[i] && busy_q[i] && (tag_q[i] == commit_rob_id);
    end
  end

  // Rename takes priority over retire, so a younger producer keeps ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (commit_hit[i]) begin
          value_q[i] <= commit_value;
        end
        if (flush) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (rename_hit[i]) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= rename_rob_id;
        end else if (retire_hit[i]) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end
    end
  end

  logic [REG_W-1:0]    rd_idx   [2];
  logic [DATA_W-1:0]   rd_value [2];
  logic                rd_busy  [2];
  logic [ROB_ID_W-1:0] rd_tag   [2];

  assign rd_idx[0] = rs1;
  assign rd_idx[1] = rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_value[p] = value_q[rd_idx[p]];
      rd_busy[p]  = busy_q[rd_idx[p]];
      rd_tag[p]   = tag_q[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle rename is deliberately ignored here; the dispatcher tracks its own dependency.
      if (commit_en && (rd_idx[p] == commit_rd)) begin
        rd_value[p] = commit_value;
        if (rd_busy[p] && (rd_tag[p] == commit_rob_id)) begin
          rd_busy[p] = 1'b0;
        end
      end
`endif
      if (rd_idx[p] == '0) begin
        rd_value[p] = '0;
        rd_busy[p]  = 1'b0;
      end
      if (!rd_busy[p]) begin
        rd_tag[p] = '0;
      end
    end
  end

  assign rs1_value = rd_value[0];
  assign rs1_busy  = rd_busy[0];
  assign rs1_tag   = rd_tag[0];
  assign rs2_value = rd_value[1];
  assign rs2_busy  = rd_busy[1];
  assign rs2_tag   = rd_tag[1];

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags.
- Sits at the receiving end of the ROB commit path.
- Dispatcher writes the rename (rd -> ROB id) at issue and reads rs1/rs2 operand value-or-tag.
- ROB commits (ROB id, rd, value); the register retires its tag only if it still points at that ROB id. A flush clears all tags after a mispredict.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- REG_W, 5, register index width.
- DATA_W, 32, register data width.
- ROB_ID_W, 4, ROB id (tag) width; matches ROB_SIZE 16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; when low, all state holds.
- flush  in  1  mispredict flush; clears every busy bit.
- rename_en  in  1  dispatcher issues an instruction with a destination.
- rename_rd  in  REG_W  destination register.
- rename_rob_id  in  ROB_ID_W  ROB id assigned to that instruction.
- commit_en  in  1  ROB commit strobe.
- commit_rd  in  REG_W  committed destination.
- commit_rob_id  in  ROB_ID_W  ROB id being committed.
- commit_value  in  DATA_W  committed result.
- rs1  in  REG_W  read index 1.
- rs2  in  REG_W  read index 2.
- rs1_value  out  DATA_W  register value.
- rs1_busy  out  1  1 = value pending; use rs1_tag.
- rs1_tag  out  ROB_ID_W  producing ROB id (0 when not busy).
- rs2_value, rs2_busy, rs2_tag  out  DATA_W/1/ROB_ID_W  same as rs1.

Behaviour:
- State per register: value[DATA_W], busy, tag[ROB_ID_W].
- Reset (async, rst=1): all values, busy bits and tags are 0. Read outputs are therefore 0/0/0 for every index.
- Read ports are combinational from state; zero latency.
- Index 0 always reads value 0, busy 0, tag 0.
- The tag output is forced to 0 whenever busy is 0.
- Writes occur on the rising clk edge, only when rdy=1. With rdy=0 nothing changes, including flush.
- Commit (commit_en=1, commit_rd!=0):
  - value[commit_rd] <= commit_value unconditionally.
  - If busy[commit_rd] && tag[commit_rd]==commit_rob_id, then busy <= 0.
  - Otherwise tag/busy are kept, because a younger rename exists.
- Rename (rename_en=1, rename_rd!=0, flush=0): busy[rename_rd] <= 1 and tag <= rename_rob_id. The value is untouched.
- Same cycle, same register, commit and rename: the rename wins on busy/tag and the commit still writes the value.
- Flush=1: all busy bits and tags go to 0. A rename in the same cycle is dropped. A commit in the same cycle still writes its value.
- Writes to x0 are ignored for both commit and rename.
- Commit and rename to different registers are fully independent.
- Tag wrap-around: tags are compared by equality only. Correctness relies on the ROB never reusing an id while an older instance is uncommitted; no extra checks are made here.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read ports forward the commit happening in the current cycle. If commit_en && rsN==commit_rd && rsN!=0, then rsN_value = commit_value. If additionally busy && tag==commit_rob_id, the port reports rsN_busy=0 and tag 0.
  - A same-cycle rename of rsN does not affect the read; the dispatcher handles its own self-dependency.
- Undefined: read ports show only registered state. The committed value is visible from the next cycle.

Test Plan:
- Reset: assert rst mid-cycle with busy registers present -> immediately all rsN_value=0, busy=0, tag=0 without waiting for clk.
- Rename then commit: rename x5->tag 3; next cycle rs1=5 shows busy=1, tag=3. Commit (rob 3, x5, 0xDEADBEEF) -> next cycle busy=0, value=0xDEADBEEF.
- Stale commit: rename x7->tag 2, then rename x7->tag 9, then commit (rob 2, x7, 0x11) -> value=0x11, busy=1, tag=9. Commit (rob 9, 0x22) -> busy=0, value=0x22.
- Same-cycle conflict: x4 busy tag 1; in one cycle commit (rob 1, x4, 0x55) and rename x4->tag 6 -> value=0x55, busy=1, tag=6.
- Flush: x1..x3 busy with tags 4,5,6, plus flush together with rename x8->tag 7 -> all busy=0; x8 not busy. A held rdy=0 during flush makes no change.
- x0/bypass: commit (rob 0, x0, 0xFF) -> x0 reads 0. With REGFILE_BYPASS_EN, x2 busy tag 3 and commit (rob 3, x2, 0xAB) in the same cycle -> rs2 shows 0xAB, busy=0 combinationally. Without the macro it shows busy=1, tag=3 until the edge.
